// File: rtl/uart_apb_pkg.sv
// -----------------------------------------------------------------------------
// uart_apb_pkg
// Shared definitions for the APB3 UART completer: register byte offsets,
// STATUS / CTRL bit positions, the UART bit-level state encoding used by both
// the transmitter and the receiver, and the smallest usable baud divisor.
// -----------------------------------------------------------------------------
package uart_apb_pkg;

  // Register byte offsets (paddr[3:0]).
  localparam logic [3:0] OffData    = 4'h0;
  localparam logic [3:0] OffStatus  = 4'h4;
  localparam logic [3:0] OffDivisor = 4'h8;
  localparam logic [3:0] OffCtrl    = 4'hC;

  // STATUS bit positions.
  localparam int StatTxBusy    = 0;
  localparam int StatRxValid   = 1;
  localparam int StatRxOverrun = 2;
  localparam int StatFrameErr  = 3;

  // CTRL bit positions.
  localparam int CtrlTxEn  = 0;
  localparam int CtrlRxEn  = 1;
  localparam int CtrlIrqEn = 2;

  // Divisors below this value leave too few clocks per bit for mid-bit
  // sampling, so they are clamped up to it.
  localparam int MinDivisor = 3;

  // Frame phase, shared by the TX and RX state machines.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
// Receives 8N1 frames from an asynchronous serial line.
//
// Ports:
//   clk, rst     sole clock, asynchronous active-high reset
//   i_rx         serial input, asynchronous to clk, idle high
//   i_rx_en      receiver enable; dropping it aborts any frame in progress
//   i_divisor    effective divisor (already clamped); one bit = i_divisor+1 clks
//   o_byte       last assembled byte, stable while the FSM is idle
//   o_valid      one-clock pulse: o_byte holds a byte with a good stop bit
//   o_frame_err  one-clock pulse: stop bit sampled low, byte discarded
// -----------------------------------------------------------------------------
module uart_rx_deserializer
  import uart_apb_pkg::*;
#(
  parameter int DivisorWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_rx,
  input  logic                    i_rx_en,
  input  logic [DivisorWidth-1:0] i_divisor,
  output logic [7:0]              o_byte,
  output logic                    o_valid,
  output logic                    o_frame_err
);

  logic [1:0]              r_sync;
  logic                    r_rx_d;
  uart_state_t             r_state, w_state_n;
  logic [DivisorWidth-1:0] r_cnt, w_cnt_n;
  logic [2:0]              r_bit, w_bit_n;
  logic [7:0]              r_shift, w_shift_n;
  logic                    r_valid, w_valid_n;
  logic                    r_frame_err, w_frame_err_n;

  logic                    w_rx;
  logic                    w_fall;
  logic                    w_tick;
  logic [DivisorWidth-1:0] w_half_m1;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_d & ~w_rx;
  assign w_tick = (r_cnt == '0);
  // (divisor+1)/2 clocks to mid-start-bit, expressed as a down-count reload.
  assign w_half_m1 = (i_divisor - 1'b1) >> 1;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_bit_n       = r_bit;
    w_shift_n     = r_shift;
    w_valid_n     = 1'b0;
    w_frame_err_n = 1'b0;

    if (!i_rx_en) begin
      w_state_n = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            w_state_n = START;
            w_cnt_n   = w_half_m1;
          end
        end
        START: begin
          if (w_tick) begin
            // Line back high at mid-start-bit: a glitch, not a frame.
            if (w_rx) begin
              w_state_n = IDLE;
            end else begin
              w_state_n = DATA;
              w_cnt_n   = i_divisor;
              w_bit_n   = '0;
            end
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (w_tick) begin
            w_shift_n = {w_rx, r_shift[7:1]};  // LSB arrives first
            w_bit_n   = r_bit + 1'b1;
            w_cnt_n   = i_divisor;
            if (r_bit == 3'd7) w_state_n = STOP;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
        STOP: begin
          if (w_tick) begin
            w_state_n     = IDLE;
            w_valid_n     = w_rx;
            w_frame_err_n = ~w_rx;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= 2'b11;
      r_rx_d      <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_rx};
      r_rx_d      <= w_rx;
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_bit       <= w_bit_n;
      r_shift     <= w_shift_n;
      r_valid     <= w_valid_n;
      r_frame_err <= w_frame_err_n;
    end
  end

  assign o_byte      = r_shift;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/apb3_uart_completer.sv
// -----------------------------------------------------------------------------
// apb3_uart_completer
// APB3 completer fronting an 8N1 UART. Four 32-bit registers:
//   0x0 DATA    write: send byte; read: received byte (clears rx_valid)
//   0x4 STATUS  {frame_err, rx_overrun, rx_valid, tx_busy}; W1C on bits 3:2
//   0x8 DIVISOR bit time = DIVISOR+1 clocks (values below 3 act as 3)
//   0xC CTRL    {irq_en, rx_en, tx_en}
//
// Ports:
//   clk, rst                          sole clock, async active-high reset
//   paddr, pselx, penable, pwrite,
//   pwdata                            APB3 request
//   pready, prdata, pslverr           APB3 response (zero outside completion)
//   tx_o                              serial out, idle high
//   rx_i                              serial in, asynchronous
//   irq_o                             registered level interrupt
// -----------------------------------------------------------------------------
module apb3_uart_completer
  import uart_apb_pkg::*;
#(
  parameter int AddressWidth   = 32,
  parameter int DataWidth      = 32,
  parameter int DivisorWidth   = 16,
  parameter int DefaultDivisor = 867
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AddressWidth-1:0] paddr,
  input  logic                    pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DataWidth-1:0]    pwdata,
  output logic                    pready,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pslverr,
  output logic                    tx_o,
  input  logic                    rx_i,
  output logic                    irq_o
);

  // ---------------------------------------------------------------- registers
  logic [DivisorWidth-1:0] r_divisor;
  logic [2:0]              r_ctrl;
  logic [7:0]              r_rx_byte;
  logic                    r_rx_valid;
  logic                    r_rx_overrun;
  logic                    r_frame_err;
  logic                    r_irq;

  // TX machine
  uart_state_t             r_tx_state, w_tx_state_n;
  logic [DivisorWidth-1:0] r_tx_cnt, w_tx_cnt_n;
  logic [2:0]              r_tx_bit, w_tx_bit_n;
  logic [7:0]              r_tx_shift, w_tx_shift_n;

  // ------------------------------------------------------------------ decode
  logic [DivisorWidth-1:0] w_div_eff;
  logic [3:0]              w_off;
  logic                    w_access, w_addr_ok, w_data_wr, w_err, w_done;
  logic                    w_tx_busy, w_tx_accept, w_tx_tick;
  logic                    w_rd_data, w_wr_status, w_wr_divisor, w_wr_ctrl;
  logic [7:0]              w_rx_byte;
  logic                    w_rx_load, w_rx_ferr;
  logic                    w_unused;

  assign w_div_eff = (r_divisor < DivisorWidth'(MinDivisor))
                   ? DivisorWidth'(MinDivisor) : r_divisor;

  assign w_off     = paddr[3:0];
  assign w_access  = pselx & penable;
  assign w_addr_ok = (paddr[1:0] == 2'b00) && (paddr <= AddressWidth'(OffCtrl));
  assign w_data_wr = w_addr_ok && (w_off == OffData) && pwrite;
  assign w_err     = !w_addr_ok || (w_data_wr && !r_ctrl[CtrlTxEn]);
  assign w_tx_busy = (r_tx_state != IDLE);

  // Only a legal DATA write against a busy transmitter stalls; errors
  // always complete immediately.
  assign pready  = w_access && !(w_data_wr && !w_err && w_tx_busy);
  assign w_done  = w_access && pready;
  assign pslverr = w_done && w_err;

  assign w_tx_accept  = w_done && !w_err && w_data_wr;
  assign w_rd_data    = w_done && !w_err && !pwrite && (w_off == OffData);
  assign w_wr_status  = w_done && !w_err && pwrite && (w_off == OffStatus);
  assign w_wr_divisor = w_done && !w_err && pwrite && (w_off == OffDivisor);
  assign w_wr_ctrl    = w_done && !w_err && pwrite && (w_off == OffCtrl);

  assign w_unused = ^pwdata[DataWidth-1:DivisorWidth];

  always_comb begin
    prdata = '0;
    if (w_done && !w_err && !pwrite) begin
      case (w_off)
        OffData:    prdata = r_rx_valid ? DataWidth'(r_rx_byte) : '0;
        OffStatus:  prdata = DataWidth'({r_frame_err, r_rx_overrun,
                                         r_rx_valid, w_tx_busy});
        OffDivisor: prdata = DataWidth'(r_divisor);
        OffCtrl:    prdata = DataWidth'(r_ctrl);
        default:    prdata = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------- TX
  // Each phase reloads the counter with the divisor current at the bit
  // boundary, so a DIVISOR write never stretches the bit in flight.
  assign w_tx_tick = (r_tx_cnt == '0);

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    case (r_tx_state)
      IDLE: begin
        if (w_tx_accept) begin
          w_tx_state_n = START;
          w_tx_cnt_n   = w_div_eff;
          w_tx_shift_n = pwdata[7:0];
        end
      end
      START: begin
        if (w_tx_tick) begin
          w_tx_state_n = DATA;
          w_tx_cnt_n   = w_div_eff;
          w_tx_bit_n   = '0;
        end else begin
          w_tx_cnt_n = r_tx_cnt - 1'b1;
        end
      end
      DATA: begin
        if (w_tx_tick) begin
          w_tx_cnt_n   = w_div_eff;
          w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_n   = r_tx_bit + 1'b1;
          if (r_tx_bit == 3'd7) w_tx_state_n = STOP;
        end else begin
          w_tx_cnt_n = r_tx_cnt - 1'b1;
        end
      end
      STOP: begin
        if (w_tx_tick) w_tx_state_n = IDLE;
        else           w_tx_cnt_n   = r_tx_cnt - 1'b1;
      end
      default: w_tx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
    end
  end

  // Decoded straight from flops: reset forces IDLE, so the line goes high
  // as soon as rst rises.
  assign tx_o = (r_tx_state == START) ? 1'b0 :
                (r_tx_state == DATA)  ? r_tx_shift[0] : 1'b1;

  // ---------------------------------------------------------------------- RX
  uart_rx_deserializer #(
    .DivisorWidth (DivisorWidth)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (rx_i),
    .i_rx_en     (r_ctrl[CtrlRxEn]),
    .i_divisor   (w_div_eff),
    .o_byte      (w_rx_byte),
    .o_valid     (w_rx_load),
    .o_frame_err (w_rx_ferr)
  );

  // ---------------------------------------------------- register file / IRQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divisor    <= DivisorWidth'(DefaultDivisor);
      r_ctrl       <= '0;
      r_rx_byte    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_frame_err  <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_wr_divisor) r_divisor <= pwdata[DivisorWidth-1:0];
      if (w_wr_ctrl)    r_ctrl    <= pwdata[2:0];

      // A read landing with a new byte consumes the old one, so the new byte
      // is not an overrun and rx_valid stays set.
      if (w_rx_load) begin
        r_rx_byte  <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end else if (w_rd_data) begin
        r_rx_valid <= 1'b0;
      end

      if (w_rx_load && r_rx_valid && !w_rd_data)
        r_rx_overrun <= 1'b1;
      else if (w_wr_status && pwdata[StatRxOverrun])
        r_rx_overrun <= 1'b0;

      if (w_rx_ferr)
        r_frame_err <= 1'b1;
      else if (w_wr_status && pwdata[StatFrameErr])
        r_frame_err <= 1'b0;

      r_irq <= r_ctrl[CtrlIrqEn] & (r_rx_valid | r_rx_overrun | r_frame_err);
    end
  end

  assign irq_o = r_irq;

endmodule

// File: tb/tb_apb3_uart_completer.sv
// -----------------------------------------------------------------------------
// tb_apb3_uart_completer
// Directed bench for apb3_uart_completer: APB register access, TX framing and
// back-pressure, RX reception / overrun / framing error / glitch rejection,
// error responses and asynchronous reset mid-frame.
// -----------------------------------------------------------------------------
module tb_apb3_uart_completer;

  logic        clk;
  logic        rst;
  logic [31:0] paddr;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        tx_o;
  logic        rx_i;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  apb3_uart_completer dut (
    .clk     (clk),
    .rst     (rst),
    .paddr   (paddr),
    .pselx   (pselx),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pready  (pready),
    .prdata  (prdata),
    .pslverr (pslverr),
    .tx_o    (tx_o),
    .rx_i    (rx_i),
    .irq_o   (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller must be just after a rising edge. Returns just after the edge that
  // completes the transfer. waits counts every cycle of the transfer that saw
  // pready low, including the setup cycle.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wdata;
    pselx   = 1'b1;
    penable = 1'b0;
    waits   = 0;
    @(negedge clk);
    if (!pready) waits++;
    @(posedge clk);
    #1 penable = 1'b1;
    @(negedge clk);
    while (!pready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    check("pready_bound", 32'(waits < 200), 32'd1);
    rdata = prdata;
    err   = pslverr;
    @(posedge clk);
    #1;
    pselx   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    int          w;
    apb_xfer(addr, 1'b1, data, d, e, w);
    check({tag, "_slverr"}, 32'(e), 32'd0);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    int          w;
    apb_xfer(addr, 1'b0, 32'h0, d, e, w);
    check(tag, d, exp);
    check({tag, "_slverr"}, 32'(e), 32'd0);
  endtask

  // 8N1 frame at 4 clocks per bit; stop_bit lets a bad frame be sent.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      repeat (4) @(posedge clk);
      #1;
    end
    rx_i = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          w;
    logic [9:0]  frm;

    rst = 1'b1; paddr = '0; pselx = 1'b0; penable = 1'b0;
    pwrite = 1'b0; pwdata = '0; rx_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ---- reset state
    check("rst_tx_o",    32'(tx_o),    32'd1);
    check("rst_pready",  32'(pready),  32'd0);
    check("rst_prdata",  prdata,       32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_irq",     32'(irq_o),   32'd0);
    rd_check("rst_divisor", 32'h8, 32'd867);
    rd_check("rst_status",  32'h4, 32'd0);
    rd_check("rst_ctrl",    32'hC, 32'd0);

    // ---- TX: 0xA5 at 4 clocks per bit
    wr("cfg_div", 32'h8, 32'd3);
    wr("cfg_ctrl_tx", 32'hC, 32'h1);
    rd_check("div_readback", 32'h8, 32'd3);
    apb_xfer(32'h0, 1'b1, 32'hA5, d, e, w);
    check("tx_wr_slverr", 32'(e), 32'd0);
    check("tx_wr_idle_waits", 32'(w), 32'd1);  // setup cycle only
    frm = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check($sformatf("tx_bit%0d_clk%0d", i, j), 32'(tx_o), 32'(frm[i]));
      end
    end
    @(posedge clk);
    #1;
    check("tx_idle_after_frame", 32'(tx_o), 32'd1);
    rd_check("tx_status_idle", 32'h4, 32'd0);

    // ---- back-to-back writes: second one stalls for the whole 40-clock frame
    wr("tx_first", 32'h0, 32'h5A);
    apb_xfer(32'h0, 1'b1, 32'h33, d, e, w);
    check("tx_stall_slverr", 32'(e), 32'd0);
    check("tx_stall_cycles", 32'(w), 32'd40);
    idle_cycles(45);
    rd_check("tx_status_done", 32'h4, 32'd0);

    // ---- RX: single frame
    wr("cfg_ctrl_rx", 32'hC, 32'h6);
    send_frame(8'h3C, 1'b1);
    idle_cycles(8);
    check("rx_irq_set", 32'(irq_o), 32'd1);
    rd_check("rx_status_valid", 32'h4, 32'h2);
    rd_check("rx_data", 32'h0, 32'h3C);
    rd_check("rx_status_clear", 32'h4, 32'h0);
    idle_cycles(1);
    check("rx_irq_clear", 32'(irq_o), 32'd0);
    rd_check("rx_data_empty", 32'h0, 32'h0);

    // ---- RX: overrun
    send_frame(8'h11, 1'b1);
    idle_cycles(4);
    send_frame(8'h22, 1'b1);
    idle_cycles(8);
    rd_check("ovr_status", 32'h4, 32'h6);
    rd_check("ovr_data", 32'h0, 32'h22);
    wr("ovr_clear", 32'h4, 32'h4);
    rd_check("ovr_status_clear", 32'h4, 32'h0);

    // ---- RX: framing error, then a one-clock glitch
    send_frame(8'h55, 1'b0);
    idle_cycles(8);
    rd_check("ferr_status", 32'h4, 32'h8);
    check("ferr_irq", 32'(irq_o), 32'd1);
    wr("ferr_clear", 32'h4, 32'h8);
    rd_check("ferr_status_clear", 32'h4, 32'h0);
    rx_i = 1'b0;
    idle_cycles(1);
    rx_i = 1'b1;
    idle_cycles(12);
    rd_check("glitch_status", 32'h4, 32'h0);

    // ---- error responses
    apb_xfer(32'h10, 1'b0, 32'h0, d, e, w);
    check("err_0x10_slverr", 32'(e), 32'd1);
    check("err_0x10_prdata", d, 32'd0);
    check("err_0x10_waits", 32'(w), 32'd1);
    apb_xfer(32'h2, 1'b0, 32'h0, d, e, w);
    check("err_0x2_slverr", 32'(e), 32'd1);
    check("err_0x2_prdata", d, 32'd0);
    apb_xfer(32'h0, 1'b1, 32'h77, d, e, w);  // CTRL=0x6: tx_en clear
    check("err_txdis_slverr", 32'(e), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("err_txdis_tx_o%0d", i), 32'(tx_o), 32'd1);
    end
    @(posedge clk);
    #1;
    rd_check("err_txdis_status", 32'h4, 32'h0);
    check("idle_pslverr", 32'(pslverr), 32'd0);
    check("idle_prdata", prdata, 32'd0);

    // ---- asynchronous reset in the middle of a frame
    wr("rst_ctrl_tx", 32'hC, 32'h1);
    wr("rst_tx_byte", 32'h0, 32'h00);
    repeat (2) @(negedge clk);
    check("midframe_tx_low", 32'(tx_o), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midframe_rst_tx_o", 32'(tx_o), 32'd1);
    check("midframe_rst_irq", 32'(irq_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_tx_o", 32'(tx_o), 32'd1);
    rd_check("post_rst_status", 32'h4, 32'h0);
    rd_check("post_rst_divisor", 32'h8, 32'd867);
    rd_check("post_rst_ctrl", 32'hC, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
